// File: rtl/lmsm_decode_stage.sv
// Decode stage: splits 16-bit instructions into fields and expands LM/SM into per-register LW/SW micro-ops.
// Optional perf counters (perf_uop_cnt, perf_stall_cnt) are enabled by defining DECODE_PERF_CNT_EN.
module lmsm_decode_stage #(
    parameter logic [3:0] LM_OPC = 4'b1100,
    parameter logic [3:0] SM_OPC = 4'b1101,
    parameter logic [3:0] LW_OPC = 4'b0100,
    parameter logic [3:0] SW_OPC = 4'b0101
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_ra,
    output logic [2:0]  out_rb,
    output logic [2:0]  out_rc,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic        out_last
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [15:0] perf_uop_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    typedef enum logic {PASS = 1'b0, EXPAND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  base_q, base_d;
    logic        is_sm_q, is_sm_d;
    logic        valid_q, valid_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [2:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [15:0] imm_q, imm_d, pc_q, pc_d;
    logic        last_q, last_d;

    logic [2:0]  low_idx;
    logic [7:0]  mask_rest;
    logic        is_lmsm;

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    assign mask_rest = mask_q & (mask_q - 8'd1);
    assign is_lmsm   = (in_instr[15:12] == LM_OPC) || (in_instr[15:12] == SM_OPC);
    assign in_ready  = (state_q == PASS) && !stall;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        k_d      = k_q;
        base_d   = base_q;
        is_sm_d  = is_sm_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        last_d   = last_q;
        if (flush) begin
            // Redirect wins over stall and drops any instruction presented this cycle.
            state_d = PASS;
            mask_d  = 8'd0;
            k_d     = 3'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (!stall) begin
            case (state_q)
                PASS: begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (in_valid && is_lmsm) begin
                        if (in_instr[7:0] != 8'd0) begin
                            state_d = EXPAND;
                            mask_d  = in_instr[7:0];
                            base_d  = in_instr[11:9];
                            is_sm_d = (in_instr[15:12] == SM_OPC);
                            k_d     = 3'd0;
                            rc_d    = in_instr[5:3];
                            pc_d    = in_pc;
                        end
                    end else if (in_valid) begin
                        valid_d  = 1'b1;
                        last_d   = 1'b1;
                        opcode_d = in_instr[15:12];
                        ra_d     = in_instr[11:9];
                        rb_d     = in_instr[8:6];
                        rc_d     = in_instr[5:3];
                        imm_d    = {{10{in_instr[5]}}, in_instr[5:0]};
                        pc_d     = in_pc;
                    end
                end
                EXPAND: begin
                    valid_d  = 1'b1;
                    opcode_d = is_sm_q ? SW_OPC : LW_OPC;
                    ra_d     = low_idx;
                    rb_d     = base_q;
                    imm_d    = {13'd0, k_q};
                    last_d   = (mask_rest == 8'd0);
                    mask_d   = mask_rest;
                    // k restarts at the end of a sequence rather than wrapping past 7.
                    k_d      = (mask_rest == 8'd0) ? 3'd0 : k_q + 3'd1;
                    state_d  = (mask_rest == 8'd0) ? PASS : EXPAND;
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= PASS;
            mask_q   <= 8'd0;
            k_q      <= 3'd0;
            base_q   <= 3'd0;
            is_sm_q  <= 1'b0;
            valid_q  <= 1'b0;
            opcode_q <= 4'd0;
            ra_q     <= 3'd0;
            rb_q     <= 3'd0;
            rc_q     <= 3'd0;
            imm_q    <= 16'd0;
            pc_q     <= 16'd0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            k_q      <= k_d;
            base_q   <= base_d;
            is_sm_q  <= is_sm_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_opcode = opcode_q;
    assign out_ra     = ra_q;
    assign out_rb     = rb_q;
    assign out_rc     = rc_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign out_last   = last_q;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] uop_cnt_q, uop_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        uop_cnt_d   = uop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!flush && !stall && valid_d && (uop_cnt_q != 16'hFFFF))
            uop_cnt_d = uop_cnt_q + 16'd1;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uop_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            uop_cnt_q   <= uop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_uop_cnt   = uop_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lmsm_decode_stage.sv
// Scoreboard bench for lmsm_decode_stage: a reference model queues expected micro-ops per instruction driven.
// Perf counter checks are compiled in when DECODE_PERF_CNT_EN is defined.
module tb_lmsm_decode_stage;

    typedef struct packed {
        logic [3:0]  opc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rc;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        last;
    } uop_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'd0;
    logic [15:0] in_pc = 16'd0;
    logic        in_ready, out_valid, out_last;
    logic [3:0]  out_opcode;
    logic [2:0]  out_ra, out_rb, out_rc;
    logic [15:0] out_imm, out_pc;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_uop_cnt, perf_stall_cnt;
`endif

    lmsm_decode_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_ra(out_ra), .out_rb(out_rb),
        .out_rc(out_rc), .out_imm(out_imm), .out_pc(out_pc), .out_last(out_last)
`ifdef DECODE_PERF_CNT_EN
        , .perf_uop_cnt(perf_uop_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    uop_t got;
    assign got = {out_opcode, out_ra, out_rb, out_rc, out_imm, out_pc, out_last};

    uop_t exp_q[$];
    uop_t last_exp;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: what the stage should emit for one accepted instruction.
    task automatic model_push(input logic [15:0] instr, input logic [15:0] pc);
        uop_t u;
        int   k = 0;
        int   n = 0;
        if (instr[15:12] == 4'b1100 || instr[15:12] == 4'b1101) begin
            for (int i = 0; i < 8; i++) if (instr[i]) n++;
            for (int i = 0; i < 8; i++) begin
                if (instr[i]) begin
                    u.opc  = (instr[15:12] == 4'b1101) ? 4'b0101 : 4'b0100;
                    u.ra   = 3'(i);
                    u.rb   = instr[11:9];
                    u.rc   = instr[5:3];
                    u.imm  = 16'(k);
                    u.pc   = pc;
                    u.last = (k == n - 1);
                    exp_q.push_back(u);
                    k++;
                end
            end
        end else begin
            u.opc  = instr[15:12];
            u.ra   = instr[11:9];
            u.rb   = instr[8:6];
            u.rc   = instr[5:3];
            u.imm  = {{10{instr[5]}}, instr[5:0]};
            u.pc   = pc;
            u.last = 1'b1;
            exp_q.push_back(u);
        end
    endtask

    // One clock; a fresh micro-op (non-stalled, non-flushed edge) is popped and compared.
    task automatic step();
        bit s, f;
        uop_t e;
        s = stall;
        f = flush;
        @(posedge clk);
        #1;
        if (!s && !f && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_uop", {18'd0, got}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("uop op=%h ra=%0d rb=%0d imm=%0d pc=%h last=%0d", got.opc, got.ra, got.rb, got.imm, got.pc, got.last);
                check("uop", {18'd0, got}, {18'd0, e});
                last_exp = e;
            end
        end else if (s && out_valid) begin
            check("stall_hold", {18'd0, got}, {18'd0, last_exp});
        end
    endtask

    task automatic send(input logic [15:0] instr, input logic [15:0] pc);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard == 50) check("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        model_push(instr, pc);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        #12;
        check("rst_outputs", {17'd0, out_valid, got}, 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;

        // ADD with one-cycle latency
        send(16'h1298, 16'h0010);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_fields", {51'd0, out_opcode, out_ra, out_rb, out_rc}, {51'd0, 4'b0001, 3'd1, 3'd2, 3'd3});

        // LM ra=2, mask A5
        send(16'hC4A5, 16'h0020);
        cnt = 0;
        repeat (6) begin
            if (!in_ready) cnt++;
            step();
        end
        check("t2_ready_low_cycles", 64'(cnt), 64'd4);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // SM with empty mask is consumed silently
        send(16'hD200, 16'h0030);
        check("t3_no_valid", 64'(out_valid), 64'd0);
        check("t3_ready", 64'(in_ready), 64'd1);
        send(16'h1298, 16'h0034);
        check("t3_add_valid", 64'(out_valid), 64'd1);

        // SM mask FF with a 2-cycle stall after the 3rd micro-op
        send(16'hD6FF, 16'h0040);
        repeat (3) step();
        stall = 1'b1;
        step();
        check("t4_ready_stalled", 64'(in_ready), 64'd0);
        step();
        stall = 1'b0;
        drain();
        step();
        check("t4_idle", 64'(out_valid), 64'd0);

        // LM mask 0F, flush while the 2nd micro-op is visible
        send(16'hC80F, 16'h0050);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_flush_valid", 64'(out_valid), 64'd0);
        check("t5_flush_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        step();
        step();
        check("t5_no_more", 64'(out_valid), 64'd0);

        // Flush drops an instruction presented in the same cycle
        in_valid = 1'b1;
        in_instr = 16'h1298;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("t5_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-expansion
        send(16'hC80F, 16'h0060);
        step();
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_outputs", {17'd0, out_valid, got}, 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
`ifdef DECODE_PERF_CNT_EN
        check("t6_rst_perf", {32'd0, perf_uop_cnt, perf_stall_cnt}, 64'd0);
`endif
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("t6_after_rst", 64'(out_valid), 64'd0);

        send(16'h1298, 16'h0070);
        send(16'h2A7F, 16'h0072);
        send(16'h3E45, 16'h0074);
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
`ifdef DECODE_PERF_CNT_EN
        check("t6_perf_uop", 64'(perf_uop_cnt), 64'd3);
        check("t6_perf_stall", 64'(perf_stall_cnt), 64'd2);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
